// File: rtl/alu_pipe.sv
// Single-issue ALU with a registered result/flag stage and valid/ready handshakes on both sides.
// Optional iterative shift-add multiply (op 16) is built only when ALU_PIPE_MUL_EN is defined.
module alu_pipe #(
  parameter int WIDTH      = 16,
  parameter int MUL_CYCLES = WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);
  localparam int M = WIDTH - 1;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_INC  = 5'd2;
  localparam logic [4:0] OP_DEC  = 5'd3;
  localparam logic [4:0] OP_NEG  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_XOR  = 5'd7;
  localparam logic [4:0] OP_NOT  = 5'd8;
  localparam logic [4:0] OP_SHL  = 5'd9;
  localparam logic [4:0] OP_SHR  = 5'd10;
  localparam logic [4:0] OP_ROL  = 5'd11;
  localparam logic [4:0] OP_ROR  = 5'd12;
  localparam logic [4:0] OP_SLTU = 5'd13;
  localparam logic [4:0] OP_EQ   = 5'd14;
  localparam logic [4:0] OP_ADDC = 5'd15;

  if (WIDTH < 4 || WIDTH > 64 || MUL_CYCLES != WIDTH) begin : g_cfg_err
    $error("alu_pipe: WIDTH must be 4..64 and MUL_CYCLES must equal WIDTH");
  end

  logic             busy;
  logic             accept;
  logic             is_mul;
  logic             alu_load;
  logic             mul_done;
  logic             carry_reg;
  logic [WIDTH-1:0] mul_res;

  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             sub;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res_c;
  logic             arith_c;
  logic             known_c;
  logic             cout_c;
  logic             ovf_c;

  assign in_ready = !busy && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign alu_load = accept && !is_mul;

  // Single-cycle datapath: add/sub ops share one WIDTH+1 adder
  always_comb begin
    x       = a;
    y       = b;
    sub     = 1'b0;
    cin     = 1'b0;
    arith_c = 1'b0;
    known_c = 1'b1;
    res_c   = '0;
    case (op)
      OP_ADD:  arith_c = 1'b1;
      OP_SUB:  begin arith_c = 1'b1; sub = 1'b1; end
      OP_INC:  begin arith_c = 1'b1; y = WIDTH'(1); end
      OP_DEC:  begin arith_c = 1'b1; sub = 1'b1; y = WIDTH'(1); end
      OP_NEG:  begin arith_c = 1'b1; sub = 1'b1; x = '0; y = a; end
      OP_ADDC: begin arith_c = 1'b1; cin = carry_reg; end
      OP_AND:  res_c = a & b;
      OP_OR:   res_c = a | b;
      OP_XOR:  res_c = a ^ b;
      OP_NOT:  res_c = ~a;
      OP_SHL:  res_c = {a[M-1:0], 1'b0};
      OP_SHR:  res_c = {1'b0, a[M:1]};
      OP_ROL:  res_c = {a[M-1:0], a[M]};
      OP_ROR:  res_c = {a[0], a[M:1]};
      OP_SLTU: res_c = WIDTH'(a < b);
      OP_EQ:   res_c = WIDTH'(a == b);
      default: known_c = 1'b0;
    endcase
    sum = sub ? ({1'b0, x} - {1'b0, y})
              : ({1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin});
    if (arith_c) res_c = sum[M:0];
    // For subtraction, bit WIDTH of the extended difference is the borrow
    cout_c = arith_c & sum[WIDTH];
    ovf_c  = arith_c & (((x[M] ^ y[M]) == sub) & (sum[M] ^ x[M]));
  end

  // Result/flag register stage
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      cout      <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      ovf       <= 1'b0;
      carry_reg <= 1'b0;
    end else begin
      if (alu_load) begin
        out_valid <= 1'b1;
        result    <= res_c;
        cout      <= cout_c;
        zero      <= known_c && (res_c == '0);
        neg       <= res_c[M];
        ovf       <= ovf_c;
        if (arith_c) carry_reg <= cout_c;
      end else if (mul_done) begin
        out_valid <= 1'b1;
        result    <= mul_res;
        cout      <= 1'b0;
        zero      <= (mul_res == '0);
        neg       <= mul_res[M];
        ovf       <= 1'b0;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_PIPE_MUL_EN
  localparam int CW = $clog2(MUL_CYCLES + 1);
  localparam logic [4:0] OP_MUL = 5'd16;

  typedef enum logic {IDLE, MUL_RUN} state_e;
  state_e           state;
  state_e           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;

  assign is_mul  = (op == OP_MUL);
  assign busy    = (state == MUL_RUN);
  assign acc_nxt = mplier[0] ? acc + mcand : acc;
  assign mul_res = acc_nxt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mul_done  = 1'b0;
    case (state)
      IDLE:    if (accept && is_mul) state_nxt = MUL_RUN;
      MUL_RUN: if (cnt == CW'(MUL_CYCLES - 1)) begin
        mul_done  = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end

  // The final iteration's sum goes straight into the result register
  always_ff @(posedge clock) begin
    if (accept && is_mul) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
    end else if (busy) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end
`else
  assign is_mul   = 1'b0;
  assign busy     = 1'b0;
  assign mul_done = 1'b0;
  assign mul_res  = '0;
`endif

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits (legal 4..64).
REQ-002 SHALL have parameter MUL_CYCLES, default WIDTH, multiply iterations; fixed at WIDTH, present for documentation only.
REQ-003 SHALL have port clock  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_valid  input  1  operation request valid.
REQ-006 SHALL have port in_ready  output  1  block can accept an operation this cycle.
REQ-007 SHALL have port op  input  5  operation select.
REQ-008 SHALL have ports a, b  input  WIDTH  operands.
REQ-009 SHALL have port out_valid  output  1  result registers hold an unconsumed result.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port result  output  WIDTH  registered result.
REQ-012 SHALL have ports cout, zero, neg, ovf  output  1 each  registered flags.

Function
REQ-013 SHALL accept an operation on a rising edge where in_valid && in_ready; op, a, b sampled only then.
REQ-014 SHALL drive in_ready = !busy && (!out_valid || out_ready); combinational, no dependence on in_valid.
REQ-015 SHALL decode op: 0 ADD a+b; 1 SUB a-b; 2 INC a; 3 DEC a; 4 NEG -a; 5 AND; 6 OR; 7 XOR; 8 NOT a; 9 SHL a by 1 (zero fill); 10 SHR a by 1 (zero fill); 11 ROL a; 12 ROR a; 13 SLTU (result = a<b unsigned, bit 0 only); 14 EQ (bit 0 only); 15 ADDC a+b+carry_reg; 16 MUL low WIDTH bits of a*b unsigned; 17..31 reserved.
REQ-016 SHALL, for reserved op, produce result 0, all flags 0, single-cycle latency.
REQ-017 SHALL compute arithmetic in WIDTH+1 bits; cout = bit WIDTH for ADD/INC/ADDC, cout = borrow (1 when minuend < subtrahend unsigned) for SUB/DEC/NEG; cout = 0 for all other ops.
REQ-018 SHALL set ovf = signed two's-complement overflow for ADD/SUB/INC/DEC/NEG/ADDC, 0 otherwise; zero = (result==0); neg = result[WIDTH-1] for every op.
REQ-019 SHALL hold an internal carry_reg updated with cout when an ADD/SUB/INC/DEC/NEG/ADDC result is loaded; unchanged by other ops.
REQ-020 SHALL load result and flags, and set out_valid, on the edge after acceptance for all ops except MUL (latency 1).
REQ-021 SHALL execute MUL as iterative shift-add: states IDLE -> MUL_RUN (WIDTH iterations, busy=1) -> load result, return IDLE; out_valid rises WIDTH cycles after acceptance edge.
REQ-022 SHALL keep result and flags stable while out_valid && !out_ready.
REQ-023 SHALL clear out_valid on an edge with out_ready && out_valid unless a new result loads that same edge (back-to-back: out_valid stays 1, new data).
REQ-024 SHALL ignore in_valid while busy or output stalled; no operation dropped or duplicated.
REQ-025 SHALL ignore out_ready when out_valid = 0.

Reset
REQ-026 SHALL on reset_n low immediately force out_valid=0, result=0, cout=zero=neg=ovf=0, carry_reg=0, busy=0, state IDLE.
REQ-027 SHALL abandon any MUL in progress on reset with no result produced; first accept allowed on first edge after reset_n high.

Configuration
REQ-028 SHALL compile MUL support only when macro ALU_PIPE_MUL_EN is defined.
REQ-029 SHALL, without ALU_PIPE_MUL_EN, treat op 16 as reserved (REQ-016), contain no MUL_RUN state, and hold busy at 0.

Verification
REQ-030 SHALL check: WIDTH=16, ADD a=0xFFFF b=0x0001 -> next cycle result=0x0000, cout=1, zero=1, ovf=0; then ADDC a=0 b=0 -> result=0x0001.
REQ-031 SHALL check: SUB a=0x8000 b=0x0001 -> result=0x7FFF, ovf=1, cout=0, neg=0; SUB a=1 b=2 -> result=0xFFFF, cout=1, neg=1.
REQ-032 SHALL check: MUL a=0x0012 b=0x0034 (macro on) -> in_ready=0 for 16 cycles, out_valid exactly 16 cycles after accept, result=0x03A8.
REQ-033 SHALL check: out_ready=0 for 5 cycles after result -> in_ready=0, result stable; out_ready=1 with in_valid=1 ROL a=0x8001 -> result=0x0003 next cycle, out_valid continuous.
REQ-034 SHALL check: reset_n low at MUL cycle 7 -> outputs zero immediately, no result after release; op 20 -> result=0, flags 0; op 16 with macro off -> result=0.
